mac_frame_accumulator: RTL and testbench

Downstream stage of the multiply-add block: it consumes the `A*B+C` result stream (`DATA_OUT`, 16 bits). Each frame is FRAME_LEN valid samples. For each frame the block accumulates an unsigned sum and tracks the unsigned maximum. When a frame completes, it presents the sum and maximum through a valid/ready output register.

---
 rtl/mac_frame_accumulator_pkg.sv | 15 +
 rtl/mac_frame_accumulator_frame_counter.sv | 27 ++
 rtl/mac_frame_accumulator.sv | 114 +++++++++++
 tb/tb_mac_frame_accumulator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mac_frame_accumulator_pkg.sv
// Shared definitions for the multiply-add stage and its frame accumulator.
package zadanie_5;

    // Width of the A*B+C result stream
    localparam int SIZE_DATA_OUT = 16;

    // Default samples per frame (must be >= 2)
    localparam int FRAME_LEN = 8;

    // Sum width wide enough that a full frame of max samples cannot overflow
    localparam int SIZE_SUM = SIZE_DATA_OUT + $clog2(FRAME_LEN);

    typedef enum logic {IDLE, ACCUM} acc_state_t;

endpackage

// File: rtl/mac_frame_accumulator_frame_counter.sv
// Sample-position counter within a frame; flags the last sample slot.
module frame_counter #(
    parameter int FRAME_LEN = 8,
    parameter int CW        = $clog2(FRAME_LEN)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_last
);

    logic [CW-1:0] r_count;

    // Count accepted samples; clear takes priority over enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + CW'(1);
    end

    assign o_last = (r_count == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/mac_frame_accumulator.sv
// Frame accumulator: per-frame unsigned sum and max, presented through a
// valid/ready output register with sticky overrun detection.
module mac_frame_accumulator #(
    parameter int SIZE_DATA_IN = zadanie_5::SIZE_DATA_OUT,
    parameter int FRAME_LEN    = zadanie_5::FRAME_LEN,
    parameter int SIZE_SUM     = SIZE_DATA_IN + $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [SIZE_DATA_IN-1:0] in_data,
    input  logic                    clear,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [SIZE_SUM-1:0]     out_sum,
    output logic [SIZE_DATA_IN-1:0] out_max,
    output logic                    overrun,
    output logic                    busy
);

    import zadanie_5::*;

    acc_state_t              r_state;
    logic [SIZE_SUM-1:0]     r_acc;
    logic [SIZE_DATA_IN-1:0] r_max;
    logic                    r_out_valid;
    logic [SIZE_SUM-1:0]     r_out_sum;
    logic [SIZE_DATA_IN-1:0] r_out_max;
    logic                    r_overrun;

    logic                    w_last;
    logic                    w_done;
    logic                    w_take;
    logic                    w_cnt_clr;
    logic [SIZE_SUM-1:0]     w_sum_next;
    logic [SIZE_DATA_IN-1:0] w_max_next;

    // Clear drops any sample presented with it
    assign w_take     = in_valid && !clear;
    assign w_done     = w_take && (r_state == ACCUM) && w_last;
    assign w_cnt_clr  = clear || w_done;
    assign w_sum_next = r_acc + SIZE_SUM'(in_data);
    assign w_max_next = (in_data > r_max) ? in_data : r_max;

    frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_take),
        .i_clr  (w_cnt_clr),
        .o_last (w_last)
    );

    // Frame FSM with running sum and max
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_max   <= '0;
        end else if (clear) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_max   <= '0;
        end else if (in_valid) begin
            case (r_state)
                IDLE: begin
                    r_acc   <= SIZE_SUM'(in_data);
                    r_max   <= in_data;
                    r_state <= ACCUM;
                end
                ACCUM: begin
                    if (w_last) begin
                        r_acc   <= '0;
                        r_max   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_sum_next;
                        r_max <= w_max_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output register: load on frame completion, drop on transfer, flag overwrites
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_max   <= '0;
            r_overrun   <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_done) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum_next;
            r_out_max   <= w_max_next;
            if (r_out_valid && !out_ready)
                r_overrun <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_max   = r_out_max;
    assign overrun   = r_overrun;
    assign busy      = (r_state == ACCUM);

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Directed bench for mac_frame_accumulator with FRAME_LEN = 4.
module tb_mac_frame_accumulator;

    localparam int DW = 16;
    localparam int FL = 4;
    localparam int SW = DW + $clog2(FL);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          clear;
    logic          out_ready;
    logic          out_valid;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_max;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mac_frame_accumulator #(
        .SIZE_DATA_IN (DW),
        .FRAME_LEN    (FL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_max", 32'(out_max), 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // 1,2,3,4 consecutive, ready high
        send(16'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send(16'd2);
        send(16'd3);
        chk("t1_nodone", {31'd0, out_valid}, 32'd0);
        send(16'd4);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_sum", 32'(out_sum), 32'd10);
        chk("t1_max", 32'(out_max), 32'd4);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_drop", {31'd0, out_valid}, 32'd0);

        // 0xFFFF x4 with gaps
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF);
            if (i < 3) begin
                int gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    chk("t2_busy_gap", {31'd0, busy}, 32'd1);
                    tick();
                end
            end
        end
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_sum", 32'(out_sum), 32'h3FFFC);
        chk("t2_max", 32'(out_max), 32'hFFFF);
        tick();
        chk("t2_drop", {31'd0, out_valid}, 32'd0);

        // overrun
        out_ready = 1'b0;
        repeat (4) send(16'd1);
        chk("t3_v1", {31'd0, out_valid}, 32'd1);
        chk("t3_s1", 32'(out_sum), 32'd4);
        chk("t3_ov0", {31'd0, overrun}, 32'd0);
        tick();
        chk("t3_hold", 32'(out_sum), 32'd4);
        repeat (4) send(16'd2);
        chk("t3_v2", {31'd0, out_valid}, 32'd1);
        chk("t3_s2", 32'(out_sum), 32'd8);
        chk("t3_m2", 32'(out_max), 32'd2);
        chk("t3_ov1", {31'd0, overrun}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_drop", {31'd0, out_valid}, 32'd0);
        chk("t3_sticky", {31'd0, overrun}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t3_clr_ov", {31'd0, overrun}, 32'd0);

        // clear mid-frame, sample with clear is dropped
        send(16'd5);
        send(16'd5);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'd100;
        tick();
        clear = 1'b0; in_valid = 1'b0; in_data = '0;
        chk("t4_clr_busy", {31'd0, busy}, 32'd0);
        chk("t4_clr_valid", {31'd0, out_valid}, 32'd0);
        repeat (4) send(16'd7);
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_sum", 32'(out_sum), 32'd28);
        chk("t4_max", 32'(out_max), 32'd7);
        tick();

        // async reset mid-frame with a pending result
        out_ready = 1'b0;
        repeat (4) send(16'd1);
        send(16'd6);
        send(16'd6);
        chk("t5_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_sum", 32'(out_sum), 32'd0);
        chk("t5_max", 32'(out_max), 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        tick();
        send(16'd3);
        send(16'd9);
        send(16'd1);
        send(16'd2);
        chk("t5_rsum", 32'(out_sum), 32'd15);
        chk("t5_rmax", 32'(out_max), 32'd9);
        chk("t5_rvalid", {31'd0, out_valid}, 32'd1);

        // completion coincides with transfer
        out_ready = 1'b0;
        send(16'd10);
        send(16'd20);
        send(16'd30);
        chk("t6_held", 32'(out_sum), 32'd15);
        out_ready = 1'b1;
        send(16'd40);
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_sum", 32'(out_sum), 32'd100);
        chk("t6_max", 32'(out_max), 32'd40);
        chk("t6_ov", {31'd0, overrun}, 32'd0);
        tick();
        chk("t6_drop", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
